// File: rtl/free_list.sv
// Physical-register free list for rename: hands out the lowest-numbered free
// register on allocate and returns registers to the pool on free.
module free_list #(
  parameter int PHYS_REGS = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alloc_en,
  output logic [5:0] alloc_phys,
  output logic       alloc_valid,
  input  logic       free_en,
  input  logic [5:0] free_phys
);

  localparam logic [6:0] RegCount = 7'(PHYS_REGS);

  logic [PHYS_REGS-1:0] free_mask;
  logic [PHYS_REGS-1:0] free_mask_d;
  logic [5:0]           alloc_phys_q;
  logic [5:0]           alloc_phys_d;
  logic                 alloc_valid_q;
  logic                 alloc_valid_d;

  logic [5:0]           grant_idx;
  logic                 grant_found;
  logic                 free_legal;

  // Scanning downward lets the last hit win, leaving the lowest free index.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = PHYS_REGS - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        grant_idx   = 6'(i);
        grant_found = 1'b1;
      end
    end
  end

  assign free_legal = free_en && ({1'b0, free_phys} < RegCount);

  // The grant is taken from the pre-edge mask, so a register freed this cycle
  // only becomes grantable on the following cycle.
  always_comb begin
    free_mask_d   = free_mask;
    alloc_phys_d  = alloc_phys_q;
    alloc_valid_d = alloc_valid_q;
    if (alloc_en) begin
      alloc_valid_d = grant_found;
      alloc_phys_d  = grant_found ? grant_idx : 6'd0;
      if (grant_found) begin
        free_mask_d[grant_idx] = 1'b0;
      end
    end
    if (free_legal) begin
      free_mask_d[free_phys] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      free_mask     <= '1;
      alloc_phys_q  <= '0;
      alloc_valid_q <= 1'b0;
    end else begin
      free_mask     <= free_mask_d;
      alloc_phys_q  <= alloc_phys_d;
      alloc_valid_q <= alloc_valid_d;
    end
  end

  assign alloc_phys  = alloc_phys_q;
  assign alloc_valid = alloc_valid_q;

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus a random stress
// run against a lowest-first golden mask model, results queued as a scoreboard.
module tb_free_list;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       alloc_en = 1'b0;
  logic       free_en = 1'b0;
  logic [5:0] free_phys = 6'd0;
  logic [5:0] alloc_phys;
  logic       alloc_valid;

  int checks = 0;
  int failures = 0;

  // Each entry is {valid, phys} expected after one driven cycle.
  logic [6:0] expQ[$];
  logic [6:0] exp;
  logic [6:0] got;

  free_list #(.PHYS_REGS(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .alloc_en   (alloc_en),
    .alloc_phys (alloc_phys),
    .alloc_valid(alloc_valid),
    .free_en    (free_en),
    .free_phys  (free_phys)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are read on the next falling edge.
  task automatic drive(input logic a, input logic f, input logic [5:0] idx);
    alloc_en  = a;
    free_en   = f;
    free_phys = idx;
    @(posedge clk);
    @(negedge clk);
    alloc_en  = 1'b0;
    free_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 6'd0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    alloc_en = 1'b1;
    free_en  = 1'b1;
    do_reset();
    checks++;
    if (alloc_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid: got %b expected 0", alloc_valid);
    end
    checks++;
    if (alloc_phys !== 6'd0) begin
      failures++;
      $display("[TB] FAIL reset_phys: got %0d expected 0", alloc_phys);
    end
    checks++;
    if (dut.free_mask !== {64{1'b1}}) begin
      failures++;
      $display("[TB] FAIL reset_mask: got %h expected all ones", dut.free_mask);
    end
  endtask

  task automatic test_sequential_alloc();
    for (int i = 0; i < 10; i++) begin
      expQ.push_back({1'b1, 6'(i)});
      drive(1'b1, 1'b0, 6'd0);
      exp = expQ.pop_front();
      got = {alloc_valid, alloc_phys};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL seq_alloc[%0d]: got %h expected %h", i, got, exp);
      end
    end
    drive(1'b0, 1'b0, 6'd0);
    got = {alloc_valid, alloc_phys};
    checks++;
    if (got !== {1'b1, 6'd9}) begin
      failures++;
      $display("[TB] FAIL hold_outputs: got %h expected %h", got, {1'b1, 6'd9});
    end
  endtask

  task automatic test_free_realloc();
    logic [63:0] expMask;
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 6'(i));
    expMask = {64{1'b1}};
    for (int i = 5; i < 10; i++) expMask[i] = 1'b0;
    checks++;
    if (dut.free_mask !== expMask) begin
      failures++;
      $display("[TB] FAIL free_mask_after_free: got %h expected %h", dut.free_mask, expMask);
    end
    for (int i = 0; i < 5; i++) begin
      expQ.push_back({1'b1, 6'(i)});
      drive(1'b1, 1'b0, 6'd0);
      exp = expQ.pop_front();
      got = {alloc_valid, alloc_phys};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL realloc[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_full_empty();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      expQ.push_back({1'b1, 6'(i)});
      drive(1'b1, 1'b0, 6'd0);
      exp = expQ.pop_front();
      got = {alloc_valid, alloc_phys};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL fill[%0d]: got %h expected %h", i, got, exp);
      end
    end
    checks++;
    if (dut.free_mask !== 64'd0) begin
      failures++;
      $display("[TB] FAIL mask_empty: got %h expected 0", dut.free_mask);
    end
    // 65th allocate fails, then alloc+free on empty pool, then the freed reg is granted.
    expQ.push_back({1'b0, 6'd0});
    expQ.push_back({1'b0, 6'd0});
    expQ.push_back({1'b1, 6'd7});
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, k == 1, 6'd7);
      exp = expQ.pop_front();
      got = {alloc_valid, alloc_phys};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL empty_step[%0d]: got %h expected %h", k, got, exp);
      end
    end
  endtask

  task automatic test_free_order();
    logic [5:0] seq[3];
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 6'd0);
    drive(1'b0, 1'b1, 6'd2);
    drive(1'b0, 1'b1, 6'd4);
    drive(1'b0, 1'b1, 6'd4);
    seq[0] = 6'd2;
    seq[1] = 6'd4;
    seq[2] = 6'd5;
    for (int k = 0; k < 3; k++) begin
      expQ.push_back({1'b1, seq[k]});
      drive(1'b1, 1'b0, 6'd0);
      exp = expQ.pop_front();
      got = {alloc_valid, alloc_phys};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL free_order[%0d]: got %h expected %h", k, got, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 62; i++) drive(1'b1, 1'b0, 6'd0);
    expQ.push_back({1'b1, 6'd62});
    drive(1'b1, 1'b1, 6'd5);
    exp = expQ.pop_front();
    got = {alloc_valid, alloc_phys};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL simul_grant: got %h expected %h", got, exp);
    end
    checks++;
    if (dut.free_mask[5] !== 1'b1 || dut.free_mask[62] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL simul_mask: got bit5=%b bit62=%b expected 1 0",
               dut.free_mask[5], dut.free_mask[62]);
    end
    // Register 0 freed in the same cycle is not grantable; register 1 is.
    do_reset();
    drive(1'b1, 1'b0, 6'd0);
    expQ.push_back({1'b1, 6'd1});
    drive(1'b1, 1'b1, 6'd0);
    exp = expQ.pop_front();
    got = {alloc_valid, alloc_phys};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL pre_edge_grant: got %h expected %h", got, exp);
    end
    expQ.push_back({1'b1, 6'd0});
    drive(1'b1, 1'b0, 6'd0);
    exp = expQ.pop_front();
    got = {alloc_valid, alloc_phys};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL freed_next_cycle: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_random_stress();
    logic [63:0] model;
    logic        mValid;
    logic [5:0]  mPhys;
    logic        a;
    logic        f;
    logic [5:0]  idx;
    logic        hit;
    do_reset();
    model  = {64{1'b1}};
    mValid = 1'b0;
    mPhys  = 6'd0;
    for (int c = 0; c < 200; c++) begin
      a   = ($urandom_range(0, 99) < 40);
      f   = ($urandom_range(0, 99) < 30);
      idx = 6'($urandom_range(0, 63));
      if (a) begin
        hit    = 1'b0;
        mValid = 1'b0;
        mPhys  = 6'd0;
        for (int i = 0; i < 64; i++) begin
          if (!hit && model[i]) begin
            hit      = 1'b1;
            mValid   = 1'b1;
            mPhys    = 6'(i);
            model[i] = 1'b0;
          end
        end
      end
      if (f) model[idx] = 1'b1;
      expQ.push_back({mValid, mPhys});
      drive(a, f, idx);
      exp = expQ.pop_front();
      got = {alloc_valid, alloc_phys};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("[TB] FAIL stress_out[%0d]: got %h expected %h", c, got, exp);
      end
      checks++;
      if (dut.free_mask !== model) begin
        failures++;
        $display("[TB] FAIL stress_mask[%0d]: got %h expected %h", c, dut.free_mask, model);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential_alloc();
    test_free_realloc();
    test_full_empty();
    test_free_order();
    test_simultaneous();
    test_random_stress();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
